// File: rtl/reload_down_counter.sv
// Reloadable down-counter with periodic/one-shot modes, direct load, tc pulse and sticky done.
// Optional enable-qualified prescaler is compiled in when RDC_PRESCALE_EN is defined.
module reload_down_counter #(
   parameter int WIDTH = 4,
   parameter int MODES = 4,
   parameter int SEL_W = 2,
   parameter logic [WIDTH*MODES-1:0] RELOAD_TABLE = {4'd15, 4'd10, 4'd15, 4'd3},
   parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(10)
`ifdef RDC_PRESCALE_EN
   ,
   parameter int PRESCALE = 4
`endif
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             oneshot,
   input  logic [SEL_W-1:0] sel,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             done
);

   logic [WIDTH-1:0] count_r;
   logic             tc_r;
   logic             done_r;
   logic [WIDTH-1:0] count_nxt_s;
   logic             tc_nxt_s;
   logic             done_nxt_s;
   logic             step_s;

   // Out-of-range selects fall back to the last table entry.
   function automatic logic [WIDTH-1:0] table_entry(input logic [SEL_W-1:0] s);
      logic [WIDTH-1:0] entry;
      entry = RELOAD_TABLE[(MODES-1)*WIDTH +: WIDTH];
      for (int i = 0; i < MODES; i++) begin
         entry = (s == SEL_W'(i)) ? RELOAD_TABLE[i*WIDTH +: WIDTH] : entry;
      end
      return entry;
   endfunction

`ifdef RDC_PRESCALE_EN
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic [PW-1:0] pre_r;
   logic [PW-1:0] pre_nxt_s;

   // Prescale tally of enabled cycles; a step fires on the last one of each group.
   always_comb begin
      pre_nxt_s = pre_r;
      step_s    = 1'b0;
      if (load) begin
         pre_nxt_s = {PW{1'b0}};
      end else if (en) begin
         if (pre_r == PW'(PRESCALE - 1)) begin
            pre_nxt_s = {PW{1'b0}};
            step_s    = 1'b1;
         end else begin
            pre_nxt_s = pre_r + PW'(1);
         end
      end else begin
         pre_nxt_s = pre_r;
      end
   end

   // Prescale counter register.
   always_ff @(posedge clk) begin
      if (reset) begin
         pre_r <= {PW{1'b0}};
      end else begin
         pre_r <= pre_nxt_s;
      end
   end
`else
   assign step_s = en;
`endif

   // Next-state for count/tc/done: load beats stepping; tc defaults low every cycle.
   always_comb begin
      count_nxt_s = count_r;
      tc_nxt_s    = 1'b0;
      done_nxt_s  = done_r;
      if (load) begin
         count_nxt_s = load_val;
         done_nxt_s  = 1'b0;
      end else if (step_s) begin
         if (count_r != {WIDTH{1'b0}}) begin
            count_nxt_s = count_r - WIDTH'(1);
         end else if (!oneshot) begin
            count_nxt_s = table_entry(sel);
            tc_nxt_s    = 1'b1;
         end else if (!done_r) begin
            done_nxt_s = 1'b1;
            tc_nxt_s   = 1'b1;
         end else begin
            tc_nxt_s = 1'b0;
         end
      end else begin
         count_nxt_s = count_r;
      end
   end

   // Output state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_r <= RESET_VAL;
         tc_r    <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         count_r <= count_nxt_s;
         tc_r    <= tc_nxt_s;
         done_r  <= done_nxt_s;
      end
   end

   assign count = count_r;
   assign tc    = tc_r;
   assign done  = done_r;

endmodule
